mem_stage: RTL

- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the M-stage control/data fields produced by the EX/MEM register and performs loads and stores over a ready/valid data-memory bus.
- Generates byte enables and load sign/zero extension, stalls the front of the pipeline while an access is pending, and owns the MEM/WB pipeline register that feeds writeback.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - ready/valid data-memory bus between the memory stage and data memory
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: load/store over the dmem bus, stall control, MEM/WB register
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    mem_stage_if.master dmem,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW,
    output logic        BusErrW
);
    localparam int CW = (TIMEOUT < 32) ? 5 : $clog2(TIMEOUT + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        is_load, access, w_byte, w_half, w_word, misalign;
    logic        mem_req, limit_reached, timeout_hit, mis_drop, bubble;
    logic [31:0] shifted, load_data;

    logic        reg_write_q, reg_write_d;
    logic [1:0]  result_src_q, result_src_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] read_data_q, read_data_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    assign is_load  = (ResultSrcM == 2'b01);
    assign access   = MemWriteM | is_load;
    assign w_byte   = (Funct3M[1:0] == 2'b00);
    assign w_half   = (Funct3M[1:0] == 2'b01);
    assign w_word   = Funct3M[1];
    assign misalign = access & ((w_half & ALUResultM[0]) | (w_word & (ALUResultM[1:0] != 2'b00)));

    // The counter only runs in BUSY, so the issue cycle in IDLE is added back here:
    // the total wait from issue to abort is TIMEOUT cycles.
    assign limit_reached = (TIMEOUT != 0) && ((int'(cnt_q) + 2) >= TIMEOUT);
    assign timeout_hit   = (state_q == ST_BUSY) & limit_reached & ~dmem.dmem_ready;

    assign mem_req = ~reset & (((state_q == ST_IDLE) & access & ~misalign) | (state_q == ST_BUSY));
    assign StallM  = mem_req & ~dmem.dmem_ready & ~timeout_hit;

    assign dmem.dmem_req  = mem_req;
    assign dmem.dmem_we   = MemWriteM;
    assign dmem.dmem_addr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = WriteDataM;
        if (MemWriteM && w_byte) begin
            dmem.dmem_be    = 4'b0001 << ALUResultM[1:0];
            dmem.dmem_wdata = {4{WriteDataM[7:0]}};
        end else if (MemWriteM && w_half) begin
            dmem.dmem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            dmem.dmem_wdata = {2{WriteDataM[15:0]}};
        end
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = dmem.dmem_rdata >> {ALUResultM[1:0], 3'b000};

    always_comb begin
        load_data = dmem.dmem_rdata;
        if (w_byte) begin
            load_data = {{24{~Funct3M[2] & shifted[7]}}, shifted[7:0]};
        end else if (w_half) begin
            load_data = {{16{~Funct3M[2] & shifted[15]}}, shifted[15:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (mem_req && !dmem.dmem_ready) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (dmem.dmem_ready || timeout_hit) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign mis_drop = access & misalign;
    assign bubble   = StallM | mis_drop | timeout_hit;

    always_comb begin
        reg_write_d  = RegWriteM;
        result_src_d = ResultSrcM;
        alu_result_d = ALUResultM;
        read_data_d  = is_load ? load_data : 32'd0;
        rd_d         = RdM;
        pc_plus4_d   = PCPlus4M;
        misalign_d   = mis_drop;
        bus_err_d    = timeout_hit;
        if (bubble) begin
            reg_write_d  = 1'b0;
            result_src_d = 2'b00;
            alu_result_d = 32'd0;
            read_data_d  = 32'd0;
            rd_d         = 5'd0;
            pc_plus4_d   = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            alu_result_q <= 32'd0;
            read_data_q  <= 32'd0;
            rd_q         <= 5'd0;
            pc_plus4_q   <= 32'd0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign RdW        = rd_q;
    assign PCPlus4W   = pc_plus4_q;
    assign MisalignW  = misalign_q;
    assign BusErrW    = bus_err_q;
endmodule
